// File: rtl/ibex_counter_pkg.sv
// Shared constants and the CSR write-request record for the event counter bank.
// Imported by the counter bank and by the CSR block that drives it.
package ibex_counter_pkg;

  localparam int unsigned CounterMaxWidth = 64;
  localparam int unsigned CsrHalfWidth    = 32;
  // Wide enough to address the largest supported bank of 32 counters.
  localparam int unsigned CounterIdxMaxW  = 5;

  typedef struct packed {
    logic                      we;
    logic [CounterIdxMaxW-1:0] idx;
    logic                      hi;
    logic [CsrHalfWidth-1:0]   data;
  } counter_wr_t;

endpackage

// File: rtl/ibex_counter_slice.sv
// One event counter: CounterWidth value bits plus a sticky overflow flag.
// A write replaces one 32-bit half and takes priority over the increment.
module ibex_counter_slice
  import ibex_counter_pkg::*;
#(
  parameter int unsigned CounterWidth = 48
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       inc_i,
  input  logic                       wr_en_i,
  input  logic                       wr_hi_i,
  input  logic [CsrHalfWidth-1:0]    wr_data_i,
  output logic [CounterMaxWidth-1:0] value_o,
  output logic                       ovf_o,
  output logic                       wrap_o
);

  logic [CounterWidth-1:0] value_q, value_d, value_wr;
  logic                    ovf_q, ovf_d;

  // Merge the selected half into the current value; bits at or above CounterWidth are dropped.
  always_comb begin
    value_wr = value_q;
    for (int unsigned b = 0; b < CounterWidth; b++) begin
      if ((b >= CsrHalfWidth) == wr_hi_i) begin
        value_wr[b] = wr_data_i[b % CsrHalfWidth];
      end
    end
  end

  assign wrap_o = inc_i & ~wr_en_i & (&value_q);

  always_comb begin
    value_d = value_q;
    ovf_d   = ovf_q | wrap_o;
    if (wr_en_i) begin
      value_d = value_wr;
      ovf_d   = 1'b0;
    end else if (inc_i) begin
      value_d = value_q + CounterWidth'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      value_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      value_q <= value_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    value_o                 = '0;
    value_o[CounterWidth-1:0] = value_q;
  end

  assign ovf_o = ovf_q;

endmodule

// File: rtl/ibex_counter_bank.sv
// Bank of NumCounters event counters backing mhpmcounter*/mcountinhibit:
// write decode, zero-extended read mux and a single-cycle overflow interrupt pulse.
module ibex_counter_bank
  import ibex_counter_pkg::*;
#(
  parameter  int unsigned NumCounters  = 8,
  parameter  int unsigned CounterWidth = 48,
  localparam int unsigned IdxW         = (NumCounters > 1) ? $clog2(NumCounters) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NumCounters-1:0]     event_i,
  input  logic [NumCounters-1:0]     inhibit_i,
  input  logic                       we_i,
  input  logic [IdxW-1:0]            wr_idx_i,
  input  logic                       wr_hi_i,
  input  logic [CsrHalfWidth-1:0]    wr_data_i,
  input  logic [IdxW-1:0]            rd_idx_i,
  output logic [CounterMaxWidth-1:0] rd_val_o,
  output logic [NumCounters-1:0]     ovf_o,
  output logic                       ovf_irq_o
);

  counter_wr_t                wr;
  logic                       wr_accept;
  logic [NumCounters-1:0]     wr_sel;
  logic [NumCounters-1:0]     inc;
  logic [NumCounters-1:0]     wrap;
  logic [CounterMaxWidth-1:0] vals [NumCounters];
  logic                       irq_q, irq_d;

  assign wr.we   = we_i;
  assign wr.idx  = CounterIdxMaxW'(wr_idx_i);
  assign wr.hi   = wr_hi_i;
  assign wr.data = wr_data_i;

  // Upper-half writes to a counter with no upper half are dropped and do not block increments.
  assign wr_accept = wr.we && !(wr.hi && (CounterWidth <= CsrHalfWidth));

  always_comb begin
    wr_sel = '0;
    for (int unsigned i = 0; i < NumCounters; i++) begin
      wr_sel[i] = wr_accept && (wr.idx == CounterIdxMaxW'(i));
    end
  end

  assign inc = event_i & ~inhibit_i;

  for (genvar g = 0; g < NumCounters; g++) begin : g_counter
    ibex_counter_slice #(
      .CounterWidth(CounterWidth)
    ) u_slice (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .inc_i     (inc[g]),
      .wr_en_i   (wr_sel[g]),
      .wr_hi_i   (wr.hi),
      .wr_data_i (wr.data),
      .value_o   (vals[g]),
      .ovf_o     (ovf_o[g]),
      .wrap_o    (wrap[g])
    );
  end

  always_comb begin
    rd_val_o = '0;
    for (int unsigned i = 0; i < NumCounters; i++) begin
      if (rd_idx_i == IdxW'(i)) begin
        rd_val_o = vals[i];
      end
    end
  end

  assign irq_d = |wrap;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign ovf_irq_o = irq_q;

endmodule

// File: tb/tb_ibex_counter_bank.sv
// Bench for ibex_counter_bank: directed vector table, hand-written corner sequences,
// and a randomized run against an arithmetic reference model.
module tb_ibex_counter_bank;

  localparam int unsigned NC = 6;
  localparam int unsigned CW = 48;
  localparam longint unsigned Mask = (64'd1 << CW) - 64'd1;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  ev, inh;
  logic        we, hi;
  logic [2:0]  wr_idx, rd_idx;
  logic [31:0] wr_data;
  logic [63:0] rd_val;
  logic [5:0]  ovf;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  longint unsigned m_val [NC];
  bit [5:0]        m_ovf;
  bit              m_irq;

  ibex_counter_bank #(
    .NumCounters (NC),
    .CounterWidth(CW)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .event_i   (ev),
    .inhibit_i (inh),
    .we_i      (we),
    .wr_idx_i  (wr_idx),
    .wr_hi_i   (hi),
    .wr_data_i (wr_data),
    .rd_idx_i  (rd_idx),
    .rd_val_o  (rd_val),
    .ovf_o     (ovf),
    .ovf_irq_o (irq)
  );

  always #20 clk = ~clk;

  typedef struct {
    string           name;
    bit              we;
    bit [2:0]        idx;
    bit              hi;
    bit [31:0]       data;
    bit [5:0]        ev;
    bit [5:0]        inh;
    bit [2:0]        rd;
    longint unsigned exp_rd;
    bit [5:0]        exp_ovf;
    bit              exp_irq;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: applies the rules for one clock edge using the inputs currently driven.
  task automatic model_update();
    bit any;
    any = 1'b0;
    if (rst) begin
      for (int n = 0; n < NC; n++) m_val[n] = 0;
      m_ovf = '0;
      m_irq = 1'b0;
      return;
    end
    for (int n = 0; n < NC; n++) begin
      if (we && int'(wr_idx) == n) begin
        if (hi) m_val[n] = (m_val[n] & 64'hFFFF_FFFF) | ((64'(wr_data) << 32) & Mask);
        else    m_val[n] = (m_val[n] & ~64'hFFFF_FFFF) | 64'(wr_data);
        m_ovf[n] = 1'b0;
      end else if (ev[n] && !inh[n]) begin
        m_val[n] = (m_val[n] + 1) & Mask;
        if (m_val[n] == 0) begin
          m_ovf[n] = 1'b1;
          any = 1'b1;
        end
      end
    end
    m_irq = any;
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; ev = '0; inh = '0; we = 0; hi = 0; wr_idx = '0; wr_data = '0;
  endtask

  task automatic write(input int idx, input bit h, input logic [31:0] d);
    idle_inputs();
    we = 1; wr_idx = 3'(idx); hi = h; wr_data = d;
    tick();
    we = 0;
  endtask

  task automatic read_check(input string name, input int idx, input longint unsigned exp);
    rd_idx = 3'(idx);
    #1;
    check(name, rd_val, exp);
  endtask

  task automatic check_model();
    for (int i = 0; i < 8; i++) begin
      rd_idx = 3'(i);
      #1;
      check($sformatf("rand_rd%0d", i), rd_val, (i < NC) ? m_val[i] : 64'd0);
    end
    check("rand_ovf", 64'(ovf), 64'(m_ovf));
    check("rand_irq", 64'(irq), 64'(m_irq));
  endtask

  initial begin
    vecs[0]  = '{"wr_lo",        1, 3'd1, 0, 32'h10,        6'h00, 6'h00, 3'd1, 64'h10,                6'h00, 0};
    vecs[1]  = '{"inc",          0, 3'd0, 0, 32'h0,         6'h02, 6'h00, 3'd1, 64'h11,                6'h00, 0};
    vecs[2]  = '{"inhibit",      0, 3'd0, 0, 32'h0,         6'h02, 6'h02, 3'd1, 64'h11,                6'h00, 0};
    vecs[3]  = '{"wr_hi",        1, 3'd1, 1, 32'hAB,        6'h00, 6'h00, 3'd1, 64'hAB_0000_0011,      6'h00, 0};
    vecs[4]  = '{"rd_oob",       1, 3'd6, 0, 32'h55,        6'h00, 6'h00, 3'd6, 64'h0,                 6'h00, 0};
    vecs[5]  = '{"wr_oob_noeff", 0, 3'd0, 0, 32'h0,         6'h00, 6'h00, 3'd1, 64'hAB_0000_0011,      6'h00, 0};
    vecs[6]  = '{"oob_no_block", 1, 3'd7, 0, 32'h99,        6'h02, 6'h00, 3'd1, 64'hAB_0000_0012,      6'h00, 0};
    vecs[7]  = '{"wr_hi_max",    1, 3'd0, 1, 32'hFFFF,      6'h00, 6'h00, 3'd0, 64'h0000_FFFF_0000_0000, 6'h00, 0};
    vecs[8]  = '{"wr_lo_max",    1, 3'd0, 0, 32'hFFFF_FFFF, 6'h00, 6'h00, 3'd0, 64'h0000_FFFF_FFFF_FFFF, 6'h00, 0};
    vecs[9]  = '{"wrap",         0, 3'd0, 0, 32'h0,         6'h01, 6'h00, 3'd0, 64'h0,                 6'h01, 1};
    vecs[10] = '{"irq_one_cyc",  0, 3'd0, 0, 32'h0,         6'h00, 6'h00, 3'd0, 64'h0,                 6'h01, 0};
    vecs[11] = '{"clr_trunc",    1, 3'd0, 1, 32'hABCD_1234, 6'h00, 6'h00, 3'd0, 64'h0000_1234_0000_0000, 6'h00, 0};

    idle_inputs();
    rd_idx = '0;
    rst = 1;
    tick();
    tick();
    rst = 0;
    read_check("reset_rd0", 0, 64'h0);
    check("reset_ovf", 64'(ovf), 64'h0);
    check("reset_irq", 64'(irq), 64'h0);

    foreach (vecs[i]) begin
      idle_inputs();
      we = vecs[i].we; wr_idx = vecs[i].idx; hi = vecs[i].hi; wr_data = vecs[i].data;
      ev = vecs[i].ev; inh = vecs[i].inh;
      tick();
      idle_inputs();
      read_check({"vec_", vecs[i].name}, int'(vecs[i].rd), vecs[i].exp_rd);
      check({"vec_ovf_", vecs[i].name}, 64'(ovf), 64'(vecs[i].exp_ovf));
      check({"vec_irq_", vecs[i].name}, 64'(irq), 64'(vecs[i].exp_irq));
    end

    // Two counters wrapping together give one pulse; a later wrap pulses again with flags still set.
    write(4, 1, 32'hFFFF); write(4, 0, 32'hFFFF_FFFF);
    write(5, 1, 32'hFFFF); write(5, 0, 32'hFFFF_FFFF);
    ev = 6'b110000;
    tick();
    ev = '0;
    read_check("dwrap_rd4", 4, 64'h0);
    read_check("dwrap_rd5", 5, 64'h0);
    check("dwrap_ovf", 64'(ovf), 64'h30);
    check("dwrap_irq", 64'(irq), 64'h1);
    tick();
    check("dwrap_irq_drop", 64'(irq), 64'h0);
    write(1, 1, 32'hFFFF); write(1, 0, 32'hFFFF_FFFF);
    ev = 6'b000010;
    tick();
    ev = '0;
    check("rewrap_irq", 64'(irq), 64'h1);
    check("rewrap_ovf", 64'(ovf), 64'h32);
    tick();
    check("rewrap_irq_drop", 64'(irq), 64'h0);

    // Reset in the middle of counting.
    write(3, 0, 32'h1234);
    read_check("mid_pre", 3, 64'h1234);
    ev = 6'b001000;
    rst = 1;
    tick();
    idle_inputs();
    read_check("mid_rst_rd", 3, 64'h0);
    check("mid_rst_ovf", 64'(ovf), 64'h0);
    check("mid_rst_irq", 64'(irq), 64'h0);

    // Ten event cycles with inhibit during cycles 4..6.
    for (int c = 1; c <= 10; c++) begin
      ev = 6'b000001;
      inh = (c >= 4 && c <= 6) ? 6'b000001 : 6'b000000;
      tick();
    end
    idle_inputs();
    read_check("inhibit_count", 0, 64'h7);

    // Write beats a same-cycle increment.
    write(2, 0, 32'h5);
    we = 1; wr_idx = 3'd2; hi = 0; wr_data = 32'hFFFF_FFF0; ev = 6'b000100;
    tick();
    idle_inputs();
    read_check("wr_priority", 2, 64'hFFFF_FFF0);

    // Randomized run against the reference model.
    for (int c = 0; c < 500; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      ev = 6'($urandom);
      inh = 6'($urandom) & 6'($urandom);
      we = ($urandom_range(0, 3) == 0);
      wr_idx = 3'($urandom_range(0, 7));
      hi = 1'($urandom);
      case ($urandom_range(0, 3))
        0: wr_data = $urandom;
        1: wr_data = 32'hFFFF_FFFF;
        2: wr_data = 32'h0000_FFFF;
        default: wr_data = 32'($urandom_range(0, 15));
      endcase
      tick();
      check_model();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
